// File: rtl/mem_access_initiator.sv
// Load/store initiator for one port of the unified memory.
// Takes byte/half/word requests from the load/store stage, drives the memory
// port with word address, byte mask and lane-replicated data, and returns
// lane-extracted, extended load data over a valid/ready response.
module mem_access_initiator #(
  parameter int unsigned MEMORY_DEPTH_IN_BYTE = 32'd16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  offset_r, offset_s;
  logic [1:0]  size_r, size_s;
  logic        unsigned_r, unsigned_s;
  logic        write_r, write_s;
  logic        resp_valid_r, resp_valid_s;
  logic        resp_error_r, resp_error_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        mem_en_r, mem_en_s;
  logic [3:0]  mem_we_r, mem_we_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_din_r, mem_din_s;

  // Reserved size, misalignment for the access size, or address past the end of memory.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (addr >= MEMORY_DEPTH_IN_BYTE) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  // Byte write enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      2'd0:    mask = 4'b0001 << offset;
      2'd1:    mask = 4'b0011 << offset;
      2'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicate the right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      2'd0:    data = {4{wdata[7:0]}};
      2'd1:    data = {2{wdata[15:0]}};
      2'd2:    data = wdata;
      default: data = 32'd0;
    endcase
    return data;
  endfunction

  // Pick the addressed lane out of the read word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] offset,
                                               input logic uns, input logic [31:0] dout);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    lane_b = dout[{offset, 3'b000} +: 8];
    lane_h = dout[{offset[1], 4'b0000} +: 16];
    case (size)
      2'd0:    result = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    result = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: result = dout;
    endcase
    return result;
  endfunction

  // Ready depends on reset_n directly so it falls the instant reset asserts.
  assign req_ready  = (state_r == IDLE) && reset_n;
  assign resp_valid = resp_valid_r;
  assign resp_error = resp_error_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;

  // Next-state and next-output decode; every register holds unless a state changes it.
  always_comb begin
    state_s      = state_r;
    offset_s     = offset_r;
    size_s       = size_r;
    unsigned_s   = unsigned_r;
    write_s      = write_r;
    resp_valid_s = resp_valid_r;
    resp_error_s = resp_error_r;
    resp_rdata_s = resp_rdata_r;
    mem_en_s     = mem_en_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_din_s    = mem_din_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          offset_s   = req_addr[1:0];
          size_s     = req_size;
          unsigned_s = req_unsigned;
          write_s    = req_write;
          if (is_bad_req(req_size, req_addr)) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
            resp_rdata_s = 32'd0;
          end else begin
            state_s    = ISSUE;
            mem_en_s   = 1'b1;
            mem_addr_s = {req_addr[31:2], 2'b00};
            mem_we_s   = req_write ? store_mask(req_size, req_addr[1:0]) : 4'b0000;
            mem_din_s  = req_write ? store_data(req_size, req_wdata) : 32'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        mem_en_s  = 1'b0;
        mem_we_s  = 4'b0000;
        mem_din_s = 32'd0;
        if (write_r) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          resp_error_s = 1'b0;
          resp_rdata_s = 32'd0;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
        resp_error_s = 1'b0;
        resp_rdata_s = load_extract(size_r, offset_r, unsigned_r, mem_dout);
      end
      RESP: begin
        if (resp_ready) begin
          state_s      = IDLE;
          resp_valid_s = 1'b0;
          resp_error_s = 1'b0;
          resp_rdata_s = 32'd0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s      = IDLE;
        resp_valid_s = 1'b0;
        resp_error_s = 1'b0;
        resp_rdata_s = 32'd0;
        mem_en_s     = 1'b0;
        mem_we_s     = 4'b0000;
        mem_din_s    = 32'd0;
      end
    endcase
  end

  // State and output registers; reset drops mem_en at once so no write commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      offset_r     <= 2'd0;
      size_r       <= 2'd0;
      unsigned_r   <= 1'b0;
      write_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 4'b0000;
      mem_addr_r   <= 32'd0;
      mem_din_r    <= 32'd0;
    end else begin
      state_r      <= state_s;
      offset_r     <= offset_s;
      size_r       <= size_s;
      unsigned_r   <= unsigned_s;
      write_r      <= write_s;
      resp_valid_r <= resp_valid_s;
      resp_error_r <= resp_error_s;
      resp_rdata_r <= resp_rdata_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_din_r    <= mem_din_s;
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: a synchronous memory beside the DUT, a
// byte-level reference memory predicting every transaction, a per-cycle
// compare process, and literal expectations from hand calculation.
`timescale 1ns/1ps
module tb_mem_access_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'd0;

  always #5 clk = ~clk;

  mem_access_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  logic [31:0] mem_arr [0:4095];
  logic [7:0]  ref_mem [0:16383];

  int          checks = 0;
  int          failures = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_addr, exp_din, exp_rdata;
  logic [3:0]  exp_we;
  logic        exp_err;
  int          exp_lat;
  int          mem_en_cnt;
  logic [3:0]  last_we;
  logic [31:0] last_din;
  logic [31:0] got;
  logic        got_err;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, actual, required);
    end
  endtask

  // Memory with one-edge read latency, byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem_arr[mem_addr[13:2]][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_dout <= mem_arr[mem_addr[13:2]];
    end
  end

  // Per-cycle compare against the model's expectation for the current transaction.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_en) begin
        mem_en_cnt = mem_en_cnt + 1;
        last_we  = mem_we;
        last_din = mem_din;
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", {28'd0, mem_we}, {28'd0, exp_we});
        check("mem_din", mem_din, exp_din);
      end
      if (resp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
      end else begin
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_error", {31'd0, resp_error}, 32'd0);
      end
    end
  end

  // Byte-level model: compute all expectations for one request.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    int nbytes;
    logic [31:0] v;
    logic [31:0] low_mask;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = (sz == 2'd3) || ((a % nbytes) != 0) || (a >= 32'd16384);
    exp_addr = a - (a % 4);
    exp_we = w ? 4'(((1 << nbytes) - 1) << (a % 4)) : 4'd0;
    if (!w) exp_din = 32'd0;
    else if (sz == 2'd0) exp_din = {24'd0, d[7:0]} * 32'h01010101;
    else if (sz == 2'd1) exp_din = {16'd0, d[15:0]} * 32'h00010001;
    else exp_din = d;
    v = 32'd0;
    if (!exp_err && !w) begin
      for (int i = 0; i < nbytes; i++) v = v | ({24'd0, ref_mem[a + i]} << (8 * i));
      if (nbytes < 4) begin
        low_mask = (32'd1 << (8 * nbytes)) - 32'd1;
        if (!u && v[8*nbytes-1]) v = v | ~low_mask;
      end
    end
    exp_rdata = v;
    exp_lat = exp_err ? 1 : (w ? 2 : 3);
  endtask

  // One complete transaction with optional response backpressure.
  task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input int hold,
                     output logic [31:0] rdata, output logic err);
    int n;
    int lat;
    logic [31:0] first;
    model(w, sz, u, a, d);
    mem_en_cnt = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w; req_size = ~sz; req_unsigned = ~u; req_addr = ~a; req_wdata = ~d;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    rdata = resp_rdata;
    err = resp_error;
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
      end
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, first);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
    check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    check("mem_en_count", mem_en_cnt, exp_err ? 0 : 1);
    if (w && !exp_err) begin
      for (int i = 0; i < ((sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4); i++)
        ref_mem[a + i] = d[8*i +: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'd0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'd0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    mem_en_cnt = 0;
    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk_en = 1'b1;

    // Word store then load
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got, got_err);
    check("st_w_we", {28'd0, last_we}, 32'h0000000F);
    check("st_w_rdata", got, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got, got_err);
    check("ld_w_10", got, 32'hDEADBEEF);

    // Byte lanes
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, got, got_err);
    txn(1'b1, 2'd0, 1'b0, 32'h23, 32'hAAAAAA80, 0, got, got_err);
    check("st_b_we", {28'd0, last_we}, 32'h00000008);
    check("st_b_din", last_din, 32'h80808080);
    txn(1'b0, 2'd0, 1'b0, 32'h23, 32'd0, 0, got, got_err);
    check("ld_b_s", got, 32'hFFFFFF80);
    txn(1'b0, 2'd0, 1'b1, 32'h23, 32'd0, 0, got, got_err);
    check("ld_b_u", got, 32'h00000080);
    txn(1'b0, 2'd2, 1'b1, 32'h20, 32'd0, 0, got, got_err);
    check("ld_w_20", got, 32'h80223344);

    // Half
    txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h55558001, 0, got, got_err);
    check("st_h_we", {28'd0, last_we}, 32'h0000000C);
    check("st_h_din", last_din, 32'h80018001);
    txn(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 0, got, got_err);
    check("ld_h_s", got, 32'hFFFF8001);
    txn(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 0, got, got_err);
    check("ld_h_u", got, 32'h00008001);
    txn(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, 0, got, got_err);
    check("ld_b_20", got, 32'h00000044);
    txn(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 0, got, got_err);
    check("ld_h_20", got, 32'h00003344);
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, got, got_err);
    check("ld_w_20b", got, 32'h80013344);

    // Errors
    txn(1'b0, 2'd1, 1'b0, 32'h01, 32'd0, 0, got, got_err);
    check("err_half_odd", {31'd0, got_err}, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 0, got, got_err);
    check("err_word_mis", {31'd0, got_err}, 32'd1);
    txn(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 0, got, got_err);
    check("err_size3", {31'd0, got_err}, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h4000, 32'd0, 0, got, got_err);
    check("err_range", {31'd0, got_err}, 32'd1);
    txn(1'b1, 2'd0, 1'b0, 32'h4000, 32'h5A, 0, got, got_err);
    check("err_range_st", {31'd0, got_err}, 32'd1);

    // Top-of-memory boundary
    txn(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'd0, 0, got, got_err);
    check("ld_w_top", got, 32'd0);
    txn(1'b1, 2'd0, 1'b0, 32'h3FFF, 32'h0000007F, 0, got, got_err);
    txn(1'b0, 2'd0, 1'b0, 32'h3FFF, 32'd0, 0, got, got_err);
    check("ld_b_top", got, 32'h0000007F);

    // Backpressure with an ignored concurrent request
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, got, got_err);
    check("bp_rdata", got, 32'hDEADBEEF);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, got, got_err);
    check("bp_no_write", got, 32'hDEADBEEF);

    // Reset during ISSUE of a word store
    txn(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 0, got, got_err);
    model(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678);
    mem_en_cnt = 0;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_issue_en", {31'd0, mem_en}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, mem_en}, 32'd0);
    check("mid_rst_we", {28'd0, mem_we}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, got, got_err);
    check("mid_prior", got, 32'hCAFEF00D);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
